pack_rotate: RTL

PACK_ROTATE -- requirements
Module: pack_rotate

---
 rtl/pack_rotate.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pack_rotate.sv
// Byte packer: transforms each accepted byte (pass / bit-reverse / rotate) and packs
// N of them into one output word, first byte in the most significant lane.
module pack_rotate #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [W-1:0]           IN_DATA,
  input  logic [1:0]             MODE,
  input  logic [$clog2(W)-1:0]   AMT,
  input  logic                   FLUSH,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [N*W-1:0]         OUT_WORD,
  output logic                   OUT_PARTIAL,
  output logic [$clog2(N+1)-1:0] COUNT
);

  localparam int unsigned AW = $clog2(W);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   count, count_d;
  logic [N*W-1:0]  fill, fill_d;
  logic [N*W-1:0]  word_q, word_d;
  logic            part_q, part_d;
  logic            valid_q;
  logic [W-1:0]    byte_t;
  logic            accept;
  int unsigned     cnt;

  // Per-byte transform selected by mode; rotate amount is taken modulo W.
  function automatic logic [W-1:0] xform(input logic [W-1:0] d, input logic [1:0] m,
                                          input logic [AW-1:0] a);
    logic [W-1:0]   r;
    logic [2*W-1:0] dd;
    int unsigned    k;
    k  = 32'(a) % W;
    dd = {d, d};
    r  = d;
    case (m)
      2'b01: for (int i = 0; i < int'(W); i++) r[i] = d[int'(W) - 1 - i];
      2'b10: begin
        dd = dd << k;
        r  = dd[2*W-1:W];
      end
      2'b11: begin
        dd = dd >> k;
        r  = dd[W-1:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign IN_READY    = !RST && ((state == FILL) || OUT_READY);
  assign OUT_VALID   = valid_q;
  assign OUT_WORD    = word_q;
  assign OUT_PARTIAL = part_q;
  assign COUNT       = count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FILL;
      count   <= '0;
      fill    <= '0;
      word_q  <= '0;
      part_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      fill    <= fill_d;
      word_q  <= word_d;
      part_q  <= part_d;
      valid_q <= (state_d == HOLD);
    end
  end

  // Next-state and datapath; the fill register is always zero when a word starts.
  always_comb begin
    state_d = state;
    count_d = count;
    fill_d  = fill;
    word_d  = word_q;
    part_d  = part_q;
    byte_t  = xform(IN_DATA, MODE, AMT);
    accept  = IN_VALID && IN_READY;
    cnt     = 32'(count);
    case (state)
      FILL: begin
        if (accept) begin
          fill_d[(N-1-cnt)*W +: W] = byte_t;
          count_d = CW'(cnt + 1);
          if ((cnt + 1 == N) || FLUSH) begin
            word_d  = fill_d;
            part_d  = (cnt + 1 < N);
            fill_d  = '0;
            count_d = '0;
            state_d = HOLD;
          end
        end else if (FLUSH && (cnt != 0)) begin
          word_d  = fill;
          part_d  = 1'b1;
          fill_d  = '0;
          count_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          if (accept) begin
            if (N == 1) begin
              word_d = '0;
              word_d[(N-1)*W +: W] = byte_t;
              part_d = 1'b0;
            end else begin
              fill_d[(N-1)*W +: W] = byte_t;
              count_d = CW'(1);
              state_d = FILL;
            end
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule
